// File: rtl/bp_common_pkg.sv
// bp_common_pkg: shared BlackParrot memory-engine constants and types.
package bp_common_pkg;
  localparam int bp_data_resp_num_flit_gp = 4;
  localparam int bp_sv39_paddr_width_gp   = 56;
  typedef enum logic {e_flit_tx_idle, e_flit_tx_send} bp_me_flit_tx_state_e;
endpackage

// File: rtl/bp_me_wrap_counter.sv
// bp_me_wrap_counter: loadable modulo-num_p index counter.
module bp_me_wrap_counter #(
  parameter  int num_p    = 4,
  localparam int width_lp = $clog2(num_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                load_i,
  input  logic [width_lp-1:0] load_val_i,
  input  logic                incr_i,
  output logic [width_lp-1:0] cnt_o
);
  logic [width_lp-1:0] cnt_q, cnt_d;
  assign cnt_d = load_i ? load_val_i
               : incr_i ? ((cnt_q == width_lp'(num_p-1)) ? '0 : cnt_q + 1'b1)
               : cnt_q;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/bp_me_data_resp_flit_tx.sv
// bp_me_data_resp_flit_tx: serialises a cache-line data response into flits,
// critical flit first, wrapping around the line.
module bp_me_data_resp_flit_tx
  import bp_common_pkg::*;
#(
  parameter  int data_width_p  = 512,
  parameter  int num_flit_p    = bp_data_resp_num_flit_gp,
  parameter  int paddr_width_p = bp_sv39_paddr_width_gp,
  localparam int flit_width_p  = data_width_p/num_flit_p,
  localparam int idx_width     = $clog2(num_flit_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     resp_v_i,
  output logic                     resp_ready_o,
  input  logic [paddr_width_p-1:0] resp_addr_i,
  input  logic [data_width_p-1:0]  resp_data_i,
  output logic                     flit_v_o,
  input  logic                     flit_yumi_i,
  output logic [flit_width_p-1:0]  flit_data_o,
  output logic [idx_width-1:0]     flit_idx_o,
  output logic [paddr_width_p-1:0] flit_addr_o,
  output logic                     flit_last_o
);
  localparam int lg_line_lp = $clog2(data_width_p/8);
  localparam int lg_flit_lp = $clog2(flit_width_p/8);
  bp_me_flit_tx_state_e state_q, state_d;
  logic                     init_q;
  logic [paddr_width_p-1:0] addr_q;
  logic [data_width_p-1:0]  data_q;
  logic [idx_width-1:0]     sent_q;
  logic                     accept, yumi;
  assign accept = resp_v_i & resp_ready_o;
  assign yumi   = flit_yumi_i & flit_v_o;
  // init_q keeps ready low until the first clock after reset release
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= e_flit_tx_idle;
      init_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      addr_q  <= accept ? resp_addr_i : addr_q;
      data_q  <= accept ? resp_data_i : data_q;
      sent_q  <= accept ? '0 : yumi ? sent_q + 1'b1 : sent_q;
    end
  always_comb begin
    resp_ready_o = init_q & (state_q == e_flit_tx_idle);
    flit_v_o     = (state_q == e_flit_tx_send);
    state_d      = state_q;
    if (resp_v_i & init_q & (state_q == e_flit_tx_idle)) state_d = e_flit_tx_send;
    if (flit_yumi_i & flit_last_o) state_d = e_flit_tx_idle;
  end
  bp_me_wrap_counter #(.num_p(num_flit_p)) idx_cnt (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (accept),
    .load_val_i (resp_addr_i[lg_line_lp-1:lg_flit_lp]),
    .incr_i     (yumi),
    .cnt_o      (flit_idx_o)
  );
  assign flit_last_o = (state_q == e_flit_tx_send) & (sent_q == idx_width'(num_flit_p-1));
  assign flit_data_o = data_q[flit_idx_o*flit_width_p +: flit_width_p];
  assign flit_addr_o = addr_q;
endmodule

// File: tb/tb_bp_me_data_resp_flit_tx.sv
// tb_bp_me_data_resp_flit_tx: directed and randomized checks of the flit serialiser.
module tb_bp_me_data_resp_flit_tx;
  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         resp_v_i = 1'b0;
  logic         resp_ready_o;
  logic [55:0]  resp_addr_i = '0;
  logic [511:0] resp_data_i = '0;
  logic         flit_v_o;
  logic         flit_yumi_i = 1'b0;
  logic [127:0] flit_data_o;
  logic [1:0]   flit_idx_o;
  logic [55:0]  flit_addr_o;
  logic         flit_last_o;
  int checks = 0;
  int errors = 0;
  logic [55:0]  last_addr;
  logic [511:0] last_data;
  bp_me_data_resp_flit_tx dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .resp_v_i(resp_v_i), .resp_ready_o(resp_ready_o),
    .resp_addr_i(resp_addr_i), .resp_data_i(resp_data_i), .flit_v_o(flit_v_o),
    .flit_yumi_i(flit_yumi_i), .flit_data_o(flit_data_o), .flit_idx_o(flit_idx_o),
    .flit_addr_o(flit_addr_o), .flit_last_o(flit_last_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] slice(input logic [511:0] d, input int idx);
    return 128'(d >> (idx*128));
  endfunction
  task automatic chk_flit(input string tag, input logic [55:0] a, input logic [511:0] d, input int idx, input bit last);
    chk({tag, "_v"}, flit_v_o, 1'b1);
    chk({tag, "_ready"}, resp_ready_o, 1'b0);
    chk({tag, "_idx"}, flit_idx_o, idx);
    chk({tag, "_data"}, flit_data_o, slice(d, idx));
    chk({tag, "_addr"}, flit_addr_o, a);
    chk({tag, "_last"}, flit_last_o, last);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, resp_ready_o, 1'b0);
    chk({tag, "_v"}, flit_v_o, 1'b0);
    chk({tag, "_data"}, flit_data_o, 128'h0);
    chk({tag, "_idx"}, flit_idx_o, 2'd0);
    chk({tag, "_addr"}, flit_addr_o, 56'h0);
    chk({tag, "_last"}, flit_last_o, 1'b0);
  endtask
  // Offers one line, drains its flits in wrap order and checks the bubble after the last.
  task automatic send_line(input string tag, input logic [55:0] a, input logic [511:0] d,
                           input int stall_at, input int stall_len, input bit hold_v);
    int start;
    start = int'((a >> 4) & 56'h3);
    chk({tag, "_accept_ready"}, resp_ready_o, 1'b1);
    resp_v_i = 1'b1;
    resp_addr_i = a;
    resp_data_i = d;
    tick();
    resp_v_i = hold_v;
    resp_data_i = ~d;
    for (int k = 0; k < 4; k++) begin
      if (k == stall_at) begin
        flit_yumi_i = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          chk_flit({tag, "_stall"}, a, d, (start + k) % 4, k == 3);
          tick();
        end
      end
      chk_flit({tag, "_flit"}, a, d, (start + k) % 4, k == 3);
      flit_yumi_i = 1'b1;
      tick();
      flit_yumi_i = 1'b0;
    end
    chk({tag, "_bubble_ready"}, resp_ready_o, 1'b1);
    chk({tag, "_bubble_v"}, flit_v_o, 1'b0);
    last_addr = a;
    last_data = d;
  endtask
  initial begin
    logic [511:0] d;
    logic [55:0]  a;
    d = {{32{4'hD}}, {32{4'hC}}, {32{4'hB}}, {32{4'hA}}};
    #2;
    chk_reset("rst_async");
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset("rst_held");
    #3;
    reset_n_i = 1'b1;
    chk("rst_release_ready", resp_ready_o, 1'b0);
    tick();
    chk("post_rst_ready", resp_ready_o, 1'b1);
    send_line("aligned", 56'h80000000, d, -1, 0, 1'b0);
    send_line("crit3", 56'h80000030, d, -1, 0, 1'b0);
    send_line("stall", 56'h80000010, d, 1, 5, 1'b0);
    // Idle yumi pulses must not disturb anything.
    for (int i = 0; i < 3; i++) begin
      flit_yumi_i = 1'b1;
      tick();
      chk("idle_yumi_ready", resp_ready_o, 1'b1);
      chk("idle_yumi_v", flit_v_o, 1'b0);
      chk("idle_yumi_last", flit_last_o, 1'b0);
      chk("idle_yumi_idx", flit_idx_o, 2'd1);
      chk("idle_yumi_addr", flit_addr_o, last_addr);
      chk("idle_yumi_data", flit_data_o, slice(last_data, 1));
    end
    flit_yumi_i = 1'b0;
    // Reset asserted while the third flit is on the wire.
    resp_v_i = 1'b1;
    resp_addr_i = 56'h80000010;
    resp_data_i = d;
    tick();
    resp_v_i = 1'b0;
    flit_yumi_i = 1'b1;
    tick();
    tick();
    flit_yumi_i = 1'b0;
    chk_flit("pre_rst", 56'h80000010, d, 3, 1'b0);
    reset_n_i = 1'b0;
    #1;
    chk_reset("midline_rst");
    tick();
    reset_n_i = 1'b1;
    chk("midline_release_ready", resp_ready_o, 1'b0);
    tick();
    send_line("after_rst", 56'h80000030, ~d, -1, 0, 1'b0);
    for (int l = 0; l < 3; l++)
      send_line("b2b", 56'h80000020 + 56'(l << 4), d ^ 512'(l), -1, 0, 1'b1);
    resp_v_i = 1'b0;
    tick();
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
      a = {24'h0, $urandom} | (56'($urandom) << 32);
      send_line("rand", a, d, int'($urandom_range(0, 4)) - 1, int'($urandom_range(0, 3)), 1'($urandom));
    end
    resp_v_i = 1'b0;
    tick();
    chk("end_ready", resp_ready_o, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_me_data_resp_flit_tx.md
BP_ME_DATA_RESP_FLIT_TX -- requirements
Module: bp_me_data_resp_flit_tx

Interface
REQ-001 SHALL have parameter data_width_p, default 512, cache-line data width in bits.
REQ-002 SHALL have parameter num_flit_p, default bp_data_resp_num_flit_gp (4), flits per line; power of two, at least 2.
REQ-003 SHALL have parameter paddr_width_p, default bp_sv39_paddr_width_gp (56), physical address width.
REQ-004 SHALL derive flit_width_p = data_width_p/num_flit_p (default 128) and idx_width = clog2(num_flit_p) (default 2).
REQ-005 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n_i  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port resp_v_i  in  1  a full-line data response is offered.
REQ-008 SHALL have port resp_ready_o  out  1  block can accept a line.
REQ-009 SHALL have port resp_addr_i  in  paddr_width_p  line address, including the critical-byte offset.
REQ-010 SHALL have port resp_data_i  in  data_width_p  line data; flit k occupies bits [k*flit_width_p +: flit_width_p].
REQ-011 SHALL have port flit_v_o  out  1  a flit is presented.
REQ-012 SHALL have port flit_yumi_i  in  1  consumer takes the flit; legal only when flit_v_o=1.
REQ-013 SHALL have port flit_data_o  out  flit_width_p  flit payload.
REQ-014 SHALL have port flit_idx_o  out  idx_width  line position of the current flit.
REQ-015 SHALL have port flit_addr_o  out  paddr_width_p  captured line address.
REQ-016 SHALL have port flit_last_o  out  1  current flit is the final flit of the line.

Function
REQ-017 SHALL implement two states: IDLE and SEND.
REQ-018 IDLE SHALL drive resp_ready_o=1 and flit_v_o=0; SEND SHALL drive resp_ready_o=0 and flit_v_o=1.
REQ-019 In IDLE, resp_v_i & resp_ready_o SHALL capture the address and data, load the start index, clear the sent count, and move the block to SEND.
REQ-020 Start index SHALL be resp_addr_i[clog2(data_width_p/8)-1 : clog2(flit_width_p/8)] (default bits [5:4]), so the critical word goes first.
REQ-021 The first flit SHALL be valid in the cycle after acceptance (latency 1); no combinational path SHALL exist from resp_v_i to flit_v_o.
REQ-022 flit_data_o SHALL be captured-data slice flit_idx_o; flit_addr_o SHALL hold the captured address for the whole line.
REQ-023 On each flit_yumi_i, flit_idx_o SHALL increment modulo num_flit_p (wrap 3->0 by default) and the sent count SHALL increment.
REQ-024 flit_last_o SHALL be 1 exactly when sent count = num_flit_p-1, independent of the start index.
REQ-025 flit_yumi_i while flit_last_o=1 SHALL return the block to IDLE; resp_ready_o SHALL be 1 the next cycle (one bubble between lines).
REQ-026 While flit_yumi_i=0, all flit outputs SHALL hold stable, with no limit on the number of stall cycles.
REQ-027 flit_yumi_i while flit_v_o=0 SHALL be ignored.
REQ-028 Exactly num_flit_p flits SHALL be emitted per accepted line, each line index exactly once.

Reset
REQ-029 While reset_n_i=0: state=IDLE, resp_ready_o=0, flit_v_o=0, flit_data_o=0, flit_idx_o=0, flit_addr_o=0, flit_last_o=0.
REQ-030 Reset assertion mid-line SHALL drop flit_v_o immediately (asynchronously) and discard the line.
REQ-031 resp_ready_o SHALL first assert in the cycle after reset_n_i deasserts.

Structure
REQ-032 The state enum bp_me_flit_tx_state_e SHALL be added to bp_common_pkg; flit count defaults SHALL come from the existing package constants.
REQ-033 SHALL contain one sub-module, bp_me_wrap_counter: a loadable, idx_width-wide, modulo-num_flit_p incrementer that provides flit_idx_o.

Verification
REQ-034 Bench SHALL cover: addr=0x80000000, data = four words 0xA..,0xB..,0xC..,0xD.., yumi always 1 -> idx 0,1,2,3 on four consecutive cycles, last on idx 3, ready again one cycle later.
REQ-035 Bench SHALL cover: addr=0x80000030 -> idx order 3,0,1,2 with matching slices, last asserted on idx 2.
REQ-036 Bench SHALL cover: addr offset 0x10, yumi low for 5 cycles on the second flit -> outputs stable through the stall, order resumes 1,2,3,0.
REQ-037 Bench SHALL cover: reset_n_i pulled low after the 2nd yumi -> flit_v_o=0 within the same cycle; after release, a new line starts cleanly at its own start index.
REQ-038 Bench SHALL cover: resp_v_i held high across 3 back-to-back lines -> 3x4 flits in order, each acceptance exactly one cycle after the previous last flit, no lost or duplicated flits.
REQ-039 Bench SHALL cover: flit_yumi_i pulsed while in IDLE -> no state change and no output change.
